// File: rtl/ixu_execute_if.sv
// Handshake bundle between decode/regfile read, the execute pipeline and writeback.
// The slave side is the execute unit; the master side is its decode/writeback neighbourhood.
interface ixu_execute_if #(
    parameter int XLEN    = 32,
    parameter int RADDR_W = 5
);
    logic               in_valid;
    logic               in_ready;
    logic [3:0]         in_op;
    logic               in_is_nop;
    logic               in_is_imm;
    logic [RADDR_W-1:0] in_rd;
    logic [XLEN-1:0]    in_rs1_data;
    logic [XLEN-1:0]    in_rs2_data;
    logic [11:0]        in_imm;

    logic               out_valid;
    logic               out_ready;
    logic               out_we;
    logic [RADDR_W-1:0] out_rd;
    logic [XLEN-1:0]    out_result;
    logic               out_illegal;

    modport master (
        output in_valid, in_op, in_is_nop, in_is_imm, in_rd, in_rs1_data, in_rs2_data, in_imm,
        input  in_ready,
        input  out_valid, out_we, out_rd, out_result, out_illegal,
        output out_ready
    );

    modport slave (
        input  in_valid, in_op, in_is_nop, in_is_imm, in_rd, in_rs1_data, in_rs2_data, in_imm,
        output in_ready,
        output out_valid, out_we, out_rd, out_result, out_illegal,
        input  out_ready
    );
endinterface

// File: rtl/ixu_execute.sv
// Two-stage integer execute pipeline: E1 registers muxed operands, E2 registers the ALU
// result for writeback. Valid/ready on both sides, synchronous flush of both stages.
module ixu_execute #(
    parameter int XLEN    = 32,
    parameter int RADDR_W = 5
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          flush,
    ixu_execute_if.slave  bus
);
    localparam int SHW = $clog2(XLEN);

    localparam logic [3:0] OP_ADD  = 4'd0;
    localparam logic [3:0] OP_SUB  = 4'd1;
    localparam logic [3:0] OP_XOR  = 4'd2;
    localparam logic [3:0] OP_OR   = 4'd3;
    localparam logic [3:0] OP_AND  = 4'd4;
    localparam logic [3:0] OP_SLL  = 4'd5;
    localparam logic [3:0] OP_SRL  = 4'd6;
    localparam logic [3:0] OP_SRA  = 4'd7;
    localparam logic [3:0] OP_SLT  = 4'd8;
    localparam logic [3:0] OP_SLTU = 4'd9;

    logic               e1_valid;
    logic [3:0]         e1_op;
    logic [RADDR_W-1:0] e1_rd;
    logic               e1_nop;
    logic [XLEN-1:0]    e1_a;
    logic [XLEN-1:0]    e1_b;

    logic               e2_valid;
    logic               e2_nop;
    logic               e2_illegal;
    logic [RADDR_W-1:0] e2_rd;
    logic [XLEN-1:0]    e2_result;

    logic               e1_adv;
    logic               e2_adv;
    logic               accept;
    logic [XLEN-1:0]    imm_sext;
    logic [XLEN-1:0]    opnd_b;
    logic [3:0]         op_eff;
    logic [SHW-1:0]     shamt;
    logic [XLEN-1:0]    alu_result;
    logic               alu_illegal;

    assign e2_adv       = !e2_valid || bus.out_ready;
    assign e1_adv       = !e1_valid || e2_adv;
    assign bus.in_ready = e1_adv && !flush;
    assign accept       = bus.in_valid && bus.in_ready;

    assign imm_sext = {{(XLEN-12){bus.in_imm[11]}}, bus.in_imm};
    assign opnd_b   = bus.in_is_imm ? imm_sext : bus.in_rs2_data;
    // With an immediate, op 1 is ADDI: its funct7 field is immediate bits, not a SUB select.
    assign op_eff   = (bus.in_is_imm && bus.in_op == OP_SUB) ? OP_ADD : bus.in_op;

    assign shamt = e1_b[SHW-1:0];

    always_comb begin
        alu_result  = '0;
        alu_illegal = 1'b0;
        case (e1_op)
            OP_ADD:  alu_result = e1_a + e1_b;
            OP_SUB:  alu_result = e1_a - e1_b;
            OP_XOR:  alu_result = e1_a ^ e1_b;
            OP_OR:   alu_result = e1_a | e1_b;
            OP_AND:  alu_result = e1_a & e1_b;
            OP_SLL:  alu_result = e1_a << shamt;
            OP_SRL:  alu_result = e1_a >> shamt;
            OP_SRA:  alu_result = $unsigned($signed(e1_a) >>> shamt);
            OP_SLT:  alu_result = {{(XLEN-1){1'b0}}, ($signed(e1_a) < $signed(e1_b))};
            OP_SLTU: alu_result = {{(XLEN-1){1'b0}}, (e1_a < e1_b)};
            default: alu_illegal = 1'b1;
        endcase
        // Bubbles and illegal ops retire with a zero result.
        if (e1_nop || alu_illegal) begin
            alu_result = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            e1_valid <= 1'b0;
            e1_op    <= '0;
            e1_rd    <= '0;
            e1_nop   <= 1'b0;
            e1_a     <= '0;
            e1_b     <= '0;
        end else if (flush) begin
            e1_valid <= 1'b0;
        end else if (e1_adv) begin
            e1_valid <= accept;
            if (accept) begin
                e1_op  <= op_eff;
                e1_rd  <= bus.in_rd;
                e1_nop <= bus.in_is_nop;
                e1_a   <= bus.in_rs1_data;
                e1_b   <= opnd_b;
            end
        end
    end

    // E2 payload only moves when a real op arrives, so a stalled output never glitches.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            e2_valid   <= 1'b0;
            e2_nop     <= 1'b0;
            e2_illegal <= 1'b0;
            e2_rd      <= '0;
            e2_result  <= '0;
        end else if (flush) begin
            e2_valid <= 1'b0;
        end else if (e2_adv) begin
            e2_valid <= e1_valid;
            if (e1_valid) begin
                e2_nop     <= e1_nop;
                e2_illegal <= alu_illegal;
                e2_rd      <= e1_rd;
                e2_result  <= alu_result;
            end
        end
    end

    assign bus.out_valid   = e2_valid;
    assign bus.out_we      = e2_valid && !e2_nop && !e2_illegal && (e2_rd != '0);
    assign bus.out_illegal = e2_valid && e2_illegal;
    assign bus.out_rd      = e2_rd;
    assign bus.out_result  = e2_result;
endmodule

// File: tb/tb_ixu_execute.sv
// Bench for ixu_execute: directed corner ops plus a randomized valid/ready/flush/reset stream,
// scored against an in-order queue of op results computed from the ISA rules.
module tb_ixu_execute;
    typedef struct {
        logic [3:0]  op;
        logic        nop;
        logic        imm;
        logic [4:0]  rd;
        logic [31:0] a;
        logic [31:0] b2;
        logic [11:0] imm_v;
    } op_t;

    typedef struct {
        logic [31:0] res;
        logic [4:0]  rd;
        logic        we;
        logic        ill;
        int          stamp;
        logic        hc;
        logic [31:0] c_res;
        logic        c_we;
        logic        c_ill;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic flush = 1'b0;
    always #5 clk = ~clk;

    ixu_execute_if #(.XLEN(32), .RADDR_W(5)) bus ();
    ixu_execute #(.XLEN(32), .RADDR_W(5)) dut (.clk(clk), .rst_n(rst_n), .flush(flush), .bus(bus));

    int   n_vec = 0;
    int   n_err = 0;
    int   cyc   = 0;
    logic last_acc = 1'b0;
    exp_t q[$];

    op_t         cur;
    logic        hc = 1'b0;
    logic [31:0] hc_res;
    logic        hc_we, hc_ill;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%h exp=%h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic exp_t model(input op_t o);
        exp_t        e;
        logic [31:0] a, b;
        int          sh;
        e = '{default: '0};
        a = o.a;
        b = o.imm ? {{20{o.imm_v[11]}}, o.imm_v} : o.b2;
        sh = int'(b % 32);
        e.rd = o.rd;
        if (!o.nop) begin
            case (o.op)
                4'd0: e.res = a + b;
                4'd1: e.res = o.imm ? a + b : a - b;
                4'd2: e.res = a ^ b;
                4'd3: e.res = a | b;
                4'd4: e.res = a & b;
                4'd5: e.res = a << sh;
                4'd6: e.res = a >> sh;
                4'd7: e.res = a[31] ? ~((~a) >> sh) : (a >> sh);
                4'd8: e.res = (int'(a) < int'(b)) ? 32'd1 : 32'd0;
                4'd9: e.res = (a < b) ? 32'd1 : 32'd0;
                default: e.ill = 1'b1;
            endcase
        end
        e.we = !o.nop && !e.ill && (o.rd != 5'd0);
        return e;
    endfunction

    function automatic op_t mk(input logic [3:0] op, input logic nop, input logic imm,
                               input logic [4:0] rd, input logic [31:0] a,
                               input logic [31:0] b2, input logic [11:0] imm_v);
        op_t o;
        o.op = op; o.nop = nop; o.imm = imm; o.rd = rd; o.a = a; o.b2 = b2; o.imm_v = imm_v;
        return o;
    endfunction

    function automatic logic [31:0] rand_word();
        case ($urandom_range(0, 5))
            0: return 32'h8000_0000;
            1: return 32'hFFFF_FFFF;
            2: return 32'h7FFF_FFFF;
            3: return 32'd0;
            default: return $urandom;
        endcase
    endfunction

    function automatic op_t rand_op();
        op_t o;
        o.nop   = ($urandom_range(0, 7) == 0);
        o.op    = o.nop ? 4'($urandom_range(0, 9)) : 4'($urandom_range(0, 11));
        o.imm   = 1'($urandom_range(0, 1));
        o.rd    = 5'($urandom_range(0, 31));
        o.a     = rand_word();
        o.b2    = rand_word();
        o.imm_v = 12'($urandom);
        return o;
    endfunction

    task automatic drive_cur();
        bus.in_op       = cur.op;
        bus.in_is_nop   = cur.nop;
        bus.in_is_imm   = cur.imm;
        bus.in_rd       = cur.rd;
        bus.in_rs1_data = cur.a;
        bus.in_rs2_data = cur.b2;
        bus.in_imm      = cur.imm_v;
    endtask

    // One clock: called at a falling edge with inputs already driven; returns at the next one.
    task automatic cycle();
        logic exp_rdy, exp_ov, cons;
        exp_t e;
        #1;
        exp_rdy = !flush && (q.size() < 2 || bus.out_ready);
        chk("in_ready", bus.in_ready, exp_rdy);
        exp_ov = (q.size() > 0) && (q[0].stamp < cyc);
        chk("out_valid", bus.out_valid, exp_ov);
        if (exp_ov) begin
            chk("out_rd", bus.out_rd, q[0].rd);
            chk("out_we", bus.out_we, q[0].we);
            chk("out_result", bus.out_result, q[0].res);
            chk("out_illegal", bus.out_illegal, q[0].ill);
            if (q[0].hc) begin
                chk("known_result", bus.out_result, q[0].c_res);
                chk("known_we", bus.out_we, q[0].c_we);
                chk("known_illegal", bus.out_illegal, q[0].c_ill);
            end
        end else begin
            chk("idle_we", bus.out_we, 1'b0);
        end
        cons     = exp_ov && bus.out_ready;
        last_acc = bus.in_valid && exp_rdy;
        @(posedge clk);
        cyc++;
        if (cons) void'(q.pop_front());
        if (flush) begin
            q.delete();
        end else if (last_acc) begin
            e = model(cur);
            e.stamp = cyc;
            e.hc = hc; e.c_res = hc_res; e.c_we = hc_we; e.c_ill = hc_ill;
            q.push_back(e);
        end
        @(negedge clk);
    endtask

    task automatic send(input op_t o, input logic h, input logic [31:0] r,
                        input logic we, input logic ill);
        cur = o; hc = h; hc_res = r; hc_we = we; hc_ill = ill;
        drive_cur();
        bus.in_valid = 1'b1;
        for (int i = 0; i < 40; i++) begin
            cycle();
            if (last_acc) break;
        end
        chk("accept_in_time", last_acc, 1'b1);
        bus.in_valid = 1'b0;
        hc = 1'b0;
    endtask

    task automatic drain();
        bus.out_ready = 1'b1;
        for (int i = 0; i < 40 && q.size() > 0; i++) cycle();
        chk("drained", q.size(), 0);
    endtask

    task automatic do_reset();
        #2;
        rst_n = 1'b0;
        #1;
        chk("rst_out_valid", bus.out_valid, 1'b0);
        chk("rst_out_we", bus.out_we, 1'b0);
        chk("rst_out_illegal", bus.out_illegal, 1'b0);
        chk("rst_out_rd", bus.out_rd, 5'd0);
        chk("rst_out_result", bus.out_result, 32'd0);
        q.delete();
        bus.in_valid = 1'b0;
        last_acc = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        int k, sent;
        bus.in_valid = 1'b0;
        bus.out_ready = 1'b1;
        cur = mk(4'd0, 1'b0, 1'b0, 5'd0, 32'd0, 32'd0, 12'd0);
        drive_cur();
        repeat (2) @(negedge clk);
        chk("reset_out_valid", bus.out_valid, 1'b0);
        chk("reset_out_we", bus.out_we, 1'b0);
        chk("reset_out_illegal", bus.out_illegal, 1'b0);
        chk("reset_out_rd", bus.out_rd, 5'd0);
        chk("reset_out_result", bus.out_result, 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // Arithmetic corners with hand-computed results.
        send(mk(4'd0, 1'b0, 1'b1, 5'd3, 32'h7FFF_FFFF, 32'd0, 12'h001), 1'b1, 32'h8000_0000, 1'b1, 1'b0);
        drain();
        send(mk(4'd1, 1'b0, 1'b0, 5'd4, 32'd5, 32'd7, 12'd0), 1'b1, 32'hFFFF_FFFE, 1'b1, 1'b0);
        send(mk(4'd1, 1'b0, 1'b1, 5'd5, 32'd1, 32'hDEAD_BEEF, 12'hFFF), 1'b1, 32'h0000_0000, 1'b1, 1'b0);
        send(mk(4'd7, 1'b0, 1'b0, 5'd6, 32'h8000_0000, 32'h24, 12'd0), 1'b1, 32'hF800_0000, 1'b1, 1'b0);
        send(mk(4'd8, 1'b0, 1'b0, 5'd7, 32'hFFFF_FFFF, 32'd1, 12'd0), 1'b1, 32'd1, 1'b1, 1'b0);
        send(mk(4'd9, 1'b0, 1'b0, 5'd8, 32'hFFFF_FFFF, 32'd1, 12'd0), 1'b1, 32'd0, 1'b1, 1'b0);
        drain();

        // Eight-op burst with writeback stalled on cycles 3..5.
        k = 0; sent = 0;
        while ((sent < 8 || q.size() > 0) && k < 60) begin
            bus.out_ready = !(k >= 3 && k <= 5);
            if (sent < 8) begin
                cur = mk(4'($urandom_range(0, 9)), 1'b0, 1'b0, 5'(sent + 1), $urandom, $urandom, 12'd0);
                drive_cur();
            end
            bus.in_valid = (sent < 8);
            cycle();
            if (last_acc) sent++;
            k++;
        end
        bus.in_valid = 1'b0;
        chk("burst_all_retired", q.size(), 0);
        drain();

        // Fill both stages, flush for one cycle, then check the next op's latency.
        bus.out_ready = 1'b0;
        send(mk(4'd0, 1'b0, 1'b0, 5'd9, 32'd1, 32'd2, 12'd0), 1'b0, 32'd0, 1'b0, 1'b0);
        send(mk(4'd2, 1'b0, 1'b0, 5'd10, 32'hF0, 32'h0F, 12'd0), 1'b0, 32'd0, 1'b0, 1'b0);
        flush = 1'b1;
        cycle();
        flush = 1'b0;
        bus.out_ready = 1'b1;
        cycle();
        send(mk(4'd3, 1'b0, 1'b0, 5'd11, 32'hF0, 32'h0F, 12'd0), 1'b1, 32'hFF, 1'b1, 1'b0);
        drain();

        // NOP, write to x0, illegal op; then reset mid-stream.
        send(mk(4'd0, 1'b1, 1'b0, 5'd12, 32'd9, 32'd9, 12'd0), 1'b1, 32'd0, 1'b0, 1'b0);
        send(mk(4'd0, 1'b0, 1'b0, 5'd0, 32'd3, 32'd4, 12'd0), 1'b1, 32'd7, 1'b0, 1'b0);
        send(mk(4'hC, 1'b0, 1'b0, 5'd13, 32'd3, 32'd4, 12'd0), 1'b1, 32'd0, 1'b0, 1'b1);
        drain();
        bus.out_ready = 1'b0;
        send(mk(4'd0, 1'b0, 1'b0, 5'd14, 32'd1, 32'd1, 12'd0), 1'b0, 32'd0, 1'b0, 1'b0);
        send(mk(4'd0, 1'b0, 1'b0, 5'd15, 32'd2, 32'd2, 12'd0), 1'b0, 32'd0, 1'b0, 1'b0);
        do_reset();
        bus.out_ready = 1'b1;
        cycle();

        // Randomized stream with backpressure, flushes and occasional resets.
        for (int i = 0; i < 3000; i++) begin
            bus.out_ready = ($urandom_range(0, 3) != 0);
            flush = ($urandom_range(0, 24) == 0);
            if (!bus.in_valid || last_acc) begin
                bus.in_valid = ($urandom_range(0, 3) != 0);
                cur = rand_op();
                drive_cur();
            end
            if ($urandom_range(0, 399) == 0) begin
                flush = 1'b0;
                do_reset();
            end else begin
                cycle();
            end
        end
        flush = 1'b0;
        bus.in_valid = 1'b0;
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
